// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Owns the register-file write port. The in-order pipeline WB stage has
//   priority. A multi-cycle unit (MUL/DIV) hands its result over through a
//   valid/ready handshake into a 1-entry buffer, and the buffer writes when
//   the port is free. A buffered result that loses MAX_WAIT cycles forces a
//   one-cycle WB stall. When the pipe targets the same rd as the buffer, the
//   buffered (older) result writes first, which keeps WAW order.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   pipe_wb_valid      WB stage holds a valid instruction
//   pipe_reg_write     that instruction writes the register file
//   pipe_wb_rd/_data   destination and data of the WB instruction
//   mc_valid/rd/data   multi-cycle result offer
//   mc_ready           arbiter accepts the mc result this cycle
//   stall_wb           pipeline must hold WB (and earlier stages) this cycle
//   rf_we/waddr/wdata  register-file write port (combinational)
module wb_port_arbiter #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_wb_valid,
  input  logic              pipe_reg_write,
  input  logic [ADDR_W-1:0] pipe_wb_rd,
  input  logic [DATA_W-1:0] pipe_wb_data,
  input  logic              mc_valid,
  input  logic [ADDR_W-1:0] mc_rd,
  input  logic [DATA_W-1:0] mc_data,
  output logic              mc_ready,
  output logic              stall_wb,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_PEND  = 2'd1,
    ST_FORCE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   buf_rd_q, buf_rd_d;
  logic [DATA_W-1:0]   buf_data_q, buf_data_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;

  logic                pipe_wr;
  logic                waw_hit;
  logic                drain;
  logic                ready_c;
  logic                stall_c;
  logic                we_c;
  logic [ADDR_W-1:0]   waddr_c;
  logic [DATA_W-1:0]   wdata_c;

  assign pipe_wr = pipe_wb_valid & pipe_reg_write & (pipe_wb_rd != '0);
  assign waw_hit = pipe_wr & (pipe_wb_rd == buf_rd_q);

  always_comb begin
    state_d    = state_q;
    buf_rd_d   = buf_rd_q;
    buf_data_d = buf_data_q;
    wait_cnt_d = wait_cnt_q;
    drain      = 1'b0;
    ready_c    = 1'b0;
    stall_c    = 1'b0;
    we_c       = pipe_wr;
    waddr_c    = pipe_wb_rd;
    wdata_c    = pipe_wb_data;

    case (state_q)
      ST_EMPTY: begin
        ready_c = 1'b1;
        if (mc_valid) begin
          buf_rd_d   = mc_rd;
          buf_data_d = mc_data;
          wait_cnt_d = '0;
          state_d    = ST_PEND;
        end
      end
      ST_PEND: begin
        // Same-rd collision: stall the pipe so the older buffered value lands first.
        stall_c = waw_hit;
        if (!pipe_wr || waw_hit) begin
          drain = 1'b1;
        end else if (wait_cnt_q == CNT_W'(MAX_WAIT - 1)) begin
          state_d = ST_FORCE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_FORCE: begin
        stall_c = 1'b1;
        drain   = 1'b1;
      end
      default: state_d = ST_EMPTY;
    endcase

    // Buffer owns the port; an x0 destination drains without writing.
    if (drain) begin
      we_c    = (buf_rd_q != '0);
      waddr_c = buf_rd_q;
      wdata_c = buf_data_q;
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      buf_rd_q   <= '0;
      buf_data_q <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      buf_rd_q   <= buf_rd_d;
      buf_data_q <= buf_data_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Outputs are forced quiet while reset is asserted, independent of inputs.
  assign mc_ready = rst_n & ready_c;
  assign stall_wb = rst_n & stall_c;
  assign rf_we    = rst_n & we_c;
  assign rf_waddr = rst_n ? waddr_c : '0;
  assign rf_wdata = rst_n ? wdata_c : '0;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter
//   Table of per-cycle vectors {inputs, expected outputs}; expected outputs
//   are queued as each vector is driven and popped when outputs are sampled
//   on the falling edge. Reset behaviour is covered by hand-written sequences,
//   and a shadow register file tracks the final architectural values.
module tb_wb_port_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pipe_wb_valid, pipe_reg_write;
  logic [AW-1:0] pipe_wb_rd;
  logic [DW-1:0] pipe_wb_data;
  logic          mc_valid;
  logic [AW-1:0] mc_rd;
  logic [DW-1:0] mc_data;
  logic          mc_ready, stall_wb, rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  wb_port_arbiter #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .MAX_WAIT(4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pipe_wb_valid (pipe_wb_valid),
    .pipe_reg_write(pipe_reg_write),
    .pipe_wb_rd    (pipe_wb_rd),
    .pipe_wb_data  (pipe_wb_data),
    .mc_valid      (mc_valid),
    .mc_rd         (mc_rd),
    .mc_data       (mc_data),
    .mc_ready      (mc_ready),
    .stall_wb      (stall_wb),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata)
  );

  always #5 clk = ~clk;

  typedef logic [2+1+AW+DW:0] out_t;  // {ready, stall, we, waddr, wdata}

  typedef struct {
    string         name;
    logic          pv, pw;
    logic [AW-1:0] prd;
    logic [DW-1:0] pd;
    logic          mv;
    logic [AW-1:0] mrd;
    logic [DW-1:0] md;
    logic          e_ready, e_stall, e_we;
    logic [AW-1:0] e_wa;
    logic [DW-1:0] e_wd;
  } vec_t;

  vec_t vecs[$];
  out_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [DW-1:0] rf_model [32] = '{default: '0};
  int            wr_count = 0;

  always @(posedge clk) begin
    if (rst_n && rf_we) begin
      rf_model[rf_waddr] <= rf_wdata;
      wr_count++;
    end
  end

  function automatic void add(input string name,
                              input logic pv, input logic pw, input logic [AW-1:0] prd,
                              input logic [DW-1:0] pd, input logic mv, input logic [AW-1:0] mrd,
                              input logic [DW-1:0] md, input logic e_ready, input logic e_stall,
                              input logic e_we, input logic [AW-1:0] e_wa, input logic [DW-1:0] e_wd);
    vec_t v;
    v.name = name; v.pv = pv; v.pw = pw; v.prd = prd; v.pd = pd;
    v.mv = mv; v.mrd = mrd; v.md = md;
    v.e_ready = e_ready; v.e_stall = e_stall; v.e_we = e_we; v.e_wa = e_wa; v.e_wd = e_wd;
    vecs.push_back(v);
  endfunction

  function automatic out_t outs();
    return {mc_ready, stall_wb, rf_we, rf_waddr, rf_wdata};
  endfunction

  task automatic check(input string name, input out_t act, input out_t req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: {ready,stall,we,waddr,wdata} got %h want %h", name, act, req);
    end
  endtask

  task automatic check32(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic drive(input logic pv, input logic pw, input logic [AW-1:0] prd,
                       input logic [DW-1:0] pd, input logic mv, input logic [AW-1:0] mrd,
                       input logic [DW-1:0] md);
    pipe_wb_valid = pv; pipe_reg_write = pw; pipe_wb_rd = prd; pipe_wb_data = pd;
    mc_valid = mv; mc_rd = mrd; mc_data = md;
  endtask

  initial begin
    int wc;
    out_t e;

    // Vectors: name, pv pw prd pd, mv mrd md, exp ready stall we waddr wdata
    // T1 idle pipe
    add("t1_c0", 0,0,0,0,          1,3,32'hA5,  1,0,0,0,0);
    add("t1_c1", 0,0,0,0,          0,0,0,       0,0,1,3,32'hA5);
    add("t1_c2", 0,0,0,0,          0,0,0,       1,0,0,0,0);
    // T2 short contention
    add("t2_c0", 0,0,0,0,          1,9,32'h99,  1,0,0,0,0);
    add("t2_c1", 1,1,7,32'h71,     0,0,0,       0,0,1,7,32'h71);
    add("t2_c2", 1,1,7,32'h72,     0,0,0,       0,0,1,7,32'h72);
    add("t2_c3", 0,0,0,0,          0,0,0,       0,0,1,9,32'h99);
    add("t2_c4", 0,0,0,0,          0,0,0,       1,0,0,0,0);
    // T3 starvation: four lost cycles, then forced stall
    add("t3_c0", 0,0,0,0,          1,10,32'hAA, 1,0,0,0,0);
    add("t3_c1", 1,1,4,32'h41,     0,0,0,       0,0,1,4,32'h41);
    add("t3_c2", 1,1,4,32'h42,     0,0,0,       0,0,1,4,32'h42);
    add("t3_c3", 1,1,4,32'h43,     0,0,0,       0,0,1,4,32'h43);
    add("t3_c4", 1,1,4,32'h44,     0,0,0,       0,0,1,4,32'h44);
    add("t3_c5", 1,1,4,32'h45,     0,0,0,       0,1,1,10,32'hAA);
    add("t3_c6", 1,1,4,32'h45,     0,0,0,       1,0,1,4,32'h45);
    add("t3_c7", 0,0,0,0,          0,0,0,       1,0,0,0,0);
    // T4 WAW on rd=5
    add("t4_c0", 0,0,0,0,          1,5,32'h11,  1,0,0,0,0);
    add("t4_c1", 1,1,5,32'h22,     0,0,0,       0,1,1,5,32'h11);
    add("t4_c2", 1,1,5,32'h22,     0,0,0,       1,0,1,5,32'h22);
    add("t4_c3", 0,0,0,0,          0,0,0,       1,0,0,0,0);
    // T5 x0 targets
    add("t5_c0", 0,0,0,0,          1,0,32'h55,  1,0,0,0,0);
    add("t5_c1", 1,1,0,32'h77,     0,0,0,       0,0,0,0,32'h55);
    add("t5_c2", 1,1,0,32'h66,     0,0,0,       1,0,0,0,32'h66);
    // Valid but non-writing pipe leaves the port free
    add("nw_c0", 0,0,0,0,          1,2,32'h2222,1,0,0,0,0);
    add("nw_c1", 1,0,2,32'h33,     0,0,0,       0,0,1,2,32'h2222);
    // Accept while the pipe writes in EMPTY
    add("aw_c0", 1,1,6,32'h60,     1,8,32'h80,  1,0,1,6,32'h60);
    add("aw_c1", 0,0,0,0,          0,0,0,       0,0,1,8,32'h80);
    add("aw_c2", 0,0,0,0,          0,0,0,       1,0,0,0,0);

    // Reset: outputs quiet even with active inputs
    rst_n = 1'b0;
    drive(1,1,3,32'h5, 1,4,32'h9);
    #2;
    check("reset_outputs", outs(), '0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0,0,0,0, 0,0,0);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      drive(vecs[i].pv, vecs[i].pw, vecs[i].prd, vecs[i].pd,
            vecs[i].mv, vecs[i].mrd, vecs[i].md);
      exp_q.push_back({vecs[i].e_ready, vecs[i].e_stall, vecs[i].e_we, vecs[i].e_wa, vecs[i].e_wd});
      @(negedge clk);
      e = exp_q.pop_front();
      check(vecs[i].name, outs(), e);
    end

    @(posedge clk);
    #1;
    check32("rf_x5_final", rf_model[5], 32'h22);
    check32("rf_x4_final", rf_model[4], 32'h45);
    check32("rf_x10_final", rf_model[10], 32'hAA);
    check32("rf_x8_final", rf_model[8], 32'h80);

    // T6: reset asserted while a result is pending
    drive(1,1,1,32'h10, 1,28,32'hDEAD);
    @(negedge clk);
    check("t6_accept", outs(), {1'b1, 1'b0, 1'b1, 5'd1, 32'h10});
    @(posedge clk);
    #1;
    drive(1,1,1,32'h10, 0,0,0);
    @(negedge clk);
    check("t6_pend", outs(), {1'b0, 1'b0, 1'b1, 5'd1, 32'h10});
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_reset_now", outs(), '0);
    wc = wr_count;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0,0,0,0, 0,0,0);
    #1;
    check("t6_after_release", outs(), {1'b1, 1'b0, 1'b0, 5'd0, 32'h0});
    @(posedge clk);
    @(negedge clk);
    check("t6_no_drain", outs(), {1'b1, 1'b0, 1'b0, 5'd0, 32'h0});
    @(posedge clk);
    #1;
    check32("t6_write_count", 32'(wr_count), 32'(wc));
    check32("t6_x28_untouched", rf_model[28], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
